light_phase_timer: RTL and testbench

Phase-duration controller for the `traffic_light` state machine. It watches the NS/EW light outputs, times each phase, and issues the one-cycle `timer_done` pulse that advances the light FSM. Green phases are demand-actuated: the minimum green is extended up to a maximum unless a request is waiting on the cross street. It sits beside `traffic_light` and closes the loop that the light FSM leaves open.

---
 rtl/light_pkg.sv | 30 +++
 rtl/light_phase_decode.sv | 22 ++
 rtl/light_phase_timer.sv | 128 ++++++++++++
 tb/tb_light_phase_timer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/light_pkg.sv
// Shared types and lamp encoding for the traffic-light phase timer.
package light_pkg;

  localparam int LAMP_RED = 2;
  localparam int LAMP_YEL = 1;
  localparam int LAMP_GRN = 0;

  // PH_NONE is the reset value only; the decoder never produces it.
  typedef enum logic [2:0] {
    PH_NONE      = 3'd0,
    PH_NS_GREEN  = 3'd1,
    PH_NS_YELLOW = 3'd2,
    PH_EW_GREEN  = 3'd3,
    PH_EW_YELLOW = 3'd4,
    PH_ALL_RED   = 3'd5,
    PH_ILLEGAL   = 3'd6
  } phase_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FAULT = 2'd3
  } st_t;

  function automatic logic lamp_only(input logic [2:0] lamps, input int idx);
    return lamps == (3'b001 << idx);
  endfunction

endpackage

// File: rtl/light_phase_decode.sv
// Combinational lamps-to-phase decoder; anything not a legal pair is PH_ILLEGAL.
module light_phase_decode
  import light_pkg::*;
(
  input  logic [2:0] ns_light,
  input  logic [2:0] ew_light,
  output logic [2:0] phase
);

  always_comb begin
    phase = PH_ILLEGAL;
    if (lamp_only(ew_light, LAMP_RED)) begin
      if (lamp_only(ns_light, LAMP_GRN))      phase = PH_NS_GREEN;
      else if (lamp_only(ns_light, LAMP_YEL)) phase = PH_NS_YELLOW;
      else if (lamp_only(ns_light, LAMP_RED)) phase = PH_ALL_RED;
    end else if (lamp_only(ns_light, LAMP_RED)) begin
      if (lamp_only(ew_light, LAMP_GRN))      phase = PH_EW_GREEN;
      else if (lamp_only(ew_light, LAMP_YEL)) phase = PH_EW_YELLOW;
    end
  end

endmodule

// File: rtl/light_phase_timer.sv
// Phase-duration timer for traffic_light with demand-actuated greens.
// Optional LIGHT_PHASE_TIMER_FAULT_EN latches a sticky fault on illegal lamps.
module light_phase_timer
  import light_pkg::*;
#(
  parameter int GREEN_MIN   = 20,
  parameter int GREEN_MAX   = 60,
  parameter int YELLOW_TIME = 5,
  parameter int ALLRED_TIME = 2,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] ns_light,
  input  logic [2:0] ew_light,
  input  logic       ns_req,
  input  logic       ew_req,
  output logic       timer_done,
  output logic [2:0] phase,
  output logic       fault
);

  if (GREEN_MIN < 1 || GREEN_MIN > GREEN_MAX || GREEN_MAX >= 2**CNT_W) begin : g_bad_green
    $error("light_phase_timer: need 1 <= GREEN_MIN <= GREEN_MAX < 2**CNT_W");
  end
  if (YELLOW_TIME < 1) begin : g_bad_yellow
    $error("light_phase_timer: YELLOW_TIME must be >= 1");
  end
  if (ALLRED_TIME < 1) begin : g_bad_allred
    $error("light_phase_timer: ALLRED_TIME must be >= 1");
  end

  localparam logic [CNT_W-1:0] G_MIN = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] G_MAX = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] Y_T   = CNT_W'(YELLOW_TIME);
  localparam logic [CNT_W-1:0] AR_T  = CNT_W'(ALLRED_TIME);

  logic [2:0]       dec_bits;
  phase_t           dec_phase;
  phase_t           phase_q, phase_d;
  st_t              st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cross_q, cross_d;
  logic             done_q, done_d;
  logic             red_req, term;

  light_phase_decode u_decode (
    .ns_light (ns_light),
    .ew_light (ew_light),
    .phase    (dec_bits)
  );

  assign dec_phase = phase_t'(dec_bits);

  // Terminal count is judged on the post-edge counter so timer_done stays registered.
  always_comb begin
    st_d    = st_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    cross_d = cross_q;
    done_d  = 1'b0;
    term    = 1'b0;
    red_req = 1'b0;
    if (dec_phase == PH_NS_GREEN)      red_req = ew_req;
    else if (dec_phase == PH_EW_GREEN) red_req = ns_req;

    if (st_q != ST_FAULT) begin
      phase_d = dec_phase;
      if (dec_phase != phase_q) begin
        cnt_d   = CNT_W'(1);
        cross_d = 1'b0;
      end else if (st_q == ST_COUNT) begin
        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        cross_d = cross_q | red_req;
      end

      if (dec_phase != phase_q || st_q == ST_COUNT) begin
        case (dec_phase)
          PH_NS_GREEN, PH_EW_GREEN:   term = (cnt_d >= G_MIN && cross_d) || cnt_d == G_MAX;
          PH_NS_YELLOW, PH_EW_YELLOW: term = (cnt_d == Y_T);
          default:                    term = (cnt_d == AR_T);
        endcase
        done_d = term;
        st_d   = term ? ST_WAIT : ST_COUNT;
      end

`ifdef LIGHT_PHASE_TIMER_FAULT_EN
      if (dec_phase == PH_ILLEGAL) begin
        done_d = 1'b0;
        st_d   = ST_FAULT;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q    <= ST_IDLE;
      phase_q <= PH_NONE;
      cnt_q   <= '0;
      cross_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      cross_q <= cross_d;
      done_q  <= done_d;
    end
  end

  assign timer_done = done_q;
  assign phase      = phase_q;

`ifdef LIGHT_PHASE_TIMER_FAULT_EN
  logic fault_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                fault_q <= 1'b0;
    else if (st_d == ST_FAULT) fault_q <= 1'b1;
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_light_phase_timer.sv
// Directed bench for light_phase_timer with GREEN_MIN=4, GREEN_MAX=8, YELLOW=3, ALLRED=2.
module tb_light_phase_timer;
  import light_pkg::*;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  typedef struct {
    logic       rst_n;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       nsr;
    logic       ewr;
    logic       done;
    phase_t     ph;
  } row_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       ns_req;
  logic       ew_req;
  logic       timer_done;
  logic [2:0] phase;
  logic       fault;

  int   nCompared;
  int   nMismatched;
  row_t rows[$];

  light_phase_timer #(
    .GREEN_MIN   (4),
    .GREEN_MAX   (8),
    .YELLOW_TIME (3),
    .ALLRED_TIME (2),
    .CNT_W       (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ns_light   (ns_light),
    .ew_light   (ew_light),
    .ns_req     (ns_req),
    .ew_req     (ew_req),
    .timer_done (timer_done),
    .phase      (phase),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // n edges of the same inputs; only the last one expects the pulse value given.
  task automatic addRows(input int n, input logic rst, input logic [2:0] ns, input logic [2:0] ew,
                         input logic nsr, input logic ewr, input logic doneLast, input phase_t ph);
    for (int i = 0; i < n; i++) begin
      row_t r;
      r.rst_n = rst;
      r.ns    = ns;
      r.ew    = ew;
      r.nsr   = nsr;
      r.ewr   = ewr;
      r.done  = (i == n - 1) ? doneLast : 1'b0;
      r.ph    = ph;
      rows.push_back(r);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [2:0] ns, input logic [2:0] ew,
                               input logic nsr, input logic ewr);
    @(negedge clk);
    rst_n    = rst;
    ns_light = ns;
    ew_light = ew;
    ns_req   = nsr;
    ew_req   = ewr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int idx, input logic expDone,
                             input phase_t expPh, input logic expFault, input logic chkFault);
    nCompared++;
    if (timer_done !== expDone) begin
      nMismatched++;
      $display("[TB] FAIL %s_done step %0d: got %b expected %b", tag, idx, timer_done, expDone);
    end
    nCompared++;
    if (phase !== expPh) begin
      nMismatched++;
      $display("[TB] FAIL %s_phase step %0d: got %0d expected %0d", tag, idx, phase, expPh);
    end
    if (chkFault) begin
      nCompared++;
      if (fault !== expFault) begin
        nMismatched++;
        $display("[TB] FAIL %s_fault step %0d: got %b expected %b", tag, idx, fault, expFault);
      end
    end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rst_n    = 1'b0;
    ns_light = G;
    ew_light = R;
    ns_req   = 1'b0;
    ew_req   = 1'b0;

    // Full cycle with no demand, then early, late and exactly-at-minimum requests.
    addRows(1, 0, G, R, 0, 0, 0, PH_NONE);
    addRows(8, 1, G, R, 0, 0, 1, PH_NS_GREEN);
    addRows(1, 1, G, R, 0, 0, 0, PH_NS_GREEN);
    addRows(3, 1, Y, R, 0, 0, 1, PH_NS_YELLOW);
    addRows(2, 1, R, R, 0, 0, 1, PH_ALL_RED);
    addRows(8, 1, R, G, 0, 0, 1, PH_EW_GREEN);
    addRows(3, 1, R, Y, 0, 0, 1, PH_EW_YELLOW);
    addRows(2, 1, R, R, 0, 0, 1, PH_ALL_RED);
    addRows(1, 1, G, R, 0, 0, 0, PH_NS_GREEN);
    addRows(1, 1, G, R, 0, 1, 0, PH_NS_GREEN);
    addRows(2, 1, G, R, 0, 0, 1, PH_NS_GREEN);
    addRows(3, 1, Y, R, 0, 0, 1, PH_NS_YELLOW);
    addRows(2, 1, R, R, 0, 0, 1, PH_ALL_RED);
    addRows(8, 1, R, G, 0, 0, 1, PH_EW_GREEN);
    addRows(3, 1, R, Y, 0, 0, 1, PH_EW_YELLOW);
    addRows(2, 1, R, R, 0, 0, 1, PH_ALL_RED);
    addRows(6, 1, G, R, 0, 0, 0, PH_NS_GREEN);
    addRows(1, 1, G, R, 0, 1, 1, PH_NS_GREEN);
    addRows(1, 1, Y, R, 0, 1, 0, PH_NS_YELLOW);
    addRows(2, 1, Y, R, 0, 0, 1, PH_NS_YELLOW);
    addRows(2, 1, R, R, 0, 0, 1, PH_ALL_RED);
    addRows(3, 1, R, G, 0, 0, 0, PH_EW_GREEN);
    addRows(1, 1, R, G, 1, 0, 1, PH_EW_GREEN);
    addRows(2, 1, R, G, 0, 0, 0, PH_EW_GREEN);

    foreach (rows[i]) begin
      applyStimulus(rows[i].rst_n, rows[i].ns, rows[i].ew, rows[i].nsr, rows[i].ewr);
      checkOutput("table", i, rows[i].done, rows[i].ph, 1'b0, 1'b1);
    end

    // Yellow held long after its pulse must not pulse again; all-red then retimes.
    applyStimulus(0, Y, R, 0, 0);
    checkOutput("yhold_rst", 0, 0, PH_NONE, 0, 1);
    for (int i = 1; i <= 13; i++) begin
      applyStimulus(1, Y, R, 0, 0);
      checkOutput("yhold", i, (i == 3), PH_NS_YELLOW, 0, 1);
    end
    for (int i = 1; i <= 2; i++) begin
      applyStimulus(1, R, R, 0, 0);
      checkOutput("yhold_ar", i, (i == 2), PH_ALL_RED, 0, 1);
    end

    // Reset mid-green discards timing; green restarts from count 1.
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1, R, G, 0, 0);
      checkOutput("midrst_pre", i, 0, PH_EW_GREEN, 0, 1);
    end
    applyStimulus(0, R, G, 0, 0);
    checkOutput("midrst_rst", 0, 0, PH_NONE, 0, 1);
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1, R, G, 0, 0);
      checkOutput("midrst_post", i, (i == 8), PH_EW_GREEN, 0, 1);
    end

    // Both greens lit at once.
    applyStimulus(0, G, R, 0, 0);
    checkOutput("ill_rst", 0, 0, PH_NONE, 0, 1);
    for (int i = 1; i <= 2; i++) begin
      applyStimulus(1, G, R, 0, 0);
      checkOutput("ill_pre", i, 0, PH_NS_GREEN, 0, 1);
    end
    applyStimulus(1, G, G, 0, 0);
`ifdef LIGHT_PHASE_TIMER_FAULT_EN
    checkOutput("ill_enter", 1, 0, PH_ILLEGAL, 0, 0);
    for (int i = 2; i <= 8; i++) begin
      applyStimulus(1, (i % 2 == 0) ? R : G, R, 0, 0);
      checkOutput("ill_fault", i, 0, PH_ILLEGAL, 1, 1);
    end
    applyStimulus(0, G, R, 0, 0);
    checkOutput("ill_clear", 0, 0, PH_NONE, 0, 1);
`else
    checkOutput("ill_enter", 1, 0, PH_ILLEGAL, 0, 1);
    applyStimulus(1, G, G, 0, 0);
    checkOutput("ill_pulse", 2, 1, PH_ILLEGAL, 0, 1);
    applyStimulus(1, G, G, 0, 0);
    checkOutput("ill_wait", 3, 0, PH_ILLEGAL, 0, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
